// File: rtl/parity_rr_sched_pkg.sv
// Shared definitions for the parity check clients: word width, check-mode
// encodings and the odd/even check itself.
package parity_rr_sched_pkg;

   localparam int   PAR_WORD_W = 32;
   localparam logic CHK_ODD    = 1'b1;
   localparam logic CHK_EVEN   = 1'b0;

   // Odd mode reports 1 when the word has an odd number of ones, even mode when even.
   function automatic logic parity_check(input logic [PAR_WORD_W-1:0] word,
                                         input logic                  sel);
      return (sel == CHK_ODD) ? ^word : ~^word;
   endfunction

endpackage

// File: rtl/parity_rr_sched_rr_arb.sv
// Combinational round-robin arbiter: searches from last+1 upward with wrap and
// grants the first requester found; the one-hot grant is gated by en.
module rr_arb #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   input  logic           en,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_idx
);

   logic found;
   int   idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt_idx  = IDW'(idx);
            gnt[idx] = en;
         end
      end
   end

endmodule

// File: rtl/parity_rr_sched.sv
// Shares one parity checker among NREQ requesters through a round-robin
// arbiter, a single-entry response buffer and a saturating check=1 counter.
module parity_rr_sched
   import parity_rr_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CW   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [PAR_WORD_W*NREQ-1:0] req_bus,
   input  logic [NREQ-1:0]            req_sel,
   output logic [NREQ-1:0]            req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [IDW-1:0]             rsp_id,
   output logic                       rsp_check,
   output logic [CW-1:0]              chk_cnt
);

   logic                  rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]        rsp_id_q, rsp_id_d;
   logic                  rsp_check_q, rsp_check_d;
   logic [CW-1:0]         chk_cnt_q, chk_cnt_d;
   logic [IDW-1:0]        last_q, last_d;

   logic                  can_accept;
   logic                  arb_en;
   logic                  accept;
   logic [NREQ-1:0]       gnt;
   logic [IDW-1:0]        gnt_idx;
   logic [PAR_WORD_W-1:0] gnt_word;
   logic                  gnt_check;

   assign can_accept = !rsp_valid_q || rsp_ready;
   // Nothing may be accepted in a reset cycle, so the grant is masked by rst too.
   assign arb_en     = can_accept && !rst;

   rr_arb #(
      .N   (NREQ),
      .IDW (IDW)
   ) u_arb (
      .req     (req_valid),
      .last    (last_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign accept    = |(req_valid & gnt);
   assign gnt_word  = req_bus[int'(gnt_idx)*PAR_WORD_W +: PAR_WORD_W];
   assign gnt_check = parity_check(gnt_word, req_sel[gnt_idx]);

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_check_d = rsp_check_q;
      chk_cnt_d   = chk_cnt_q;
      last_d      = last_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx;
         rsp_check_d = gnt_check;
         last_d      = gnt_idx;
         if (gnt_check && (chk_cnt_q != '1)) begin
            chk_cnt_d = chk_cnt_q + CW'(1);
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_check_q <= 1'b0;
         chk_cnt_q   <= '0;
         last_q      <= IDW'(NREQ-1);
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_check_q <= rsp_check_d;
         chk_cnt_q   <= chk_cnt_d;
         last_q      <= last_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_check = rsp_check_q;
   assign chk_cnt   = chk_cnt_q;

endmodule

// File: doc/parity_rr_sched.md
Name: parity_rr_sched

Overview:
- Shares one 32-bit odd/even parity check unit among NREQ requesters.
- Each requester presents a bus word plus a sel bit: 1 requests an odd check, 0 an even check.
- A round-robin arbiter grants one requester per cycle. The shared checker result is registered into a single-entry response buffer with valid/ready backpressure.
- The block sits between the parity clients and the status/interrupt logic, and keeps a saturating count of results with check=1.

Parameters:
- NREQ, 4, number of requesters (1..16).
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.
- CW, 8, width of the saturating check counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_bus  input  32*NREQ  flattened words; requester i occupies bits [32*i+31:32*i].
- req_sel  input  NREQ  per-requester check mode: 1 = odd, 0 = even.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_check  output  1  check result.
- chk_cnt  output  CW  saturating count of accepted results with check=1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_valid=0, rsp_id=0, rsp_check=0, chk_cnt=0.
  - Priority pointer last=NREQ-1, so requester 0 has highest priority.
  - req_ready is combinational and reads 0 while rst=1.
- Reset mid-transaction: the buffered response is dropped and nothing is accepted that cycle.
- Check function: rsp_check = req_sel[g] ? ^word[g] : ~^word[g], where g is the granted index.
- can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - Search req_valid starting at index (last+1) mod NREQ, ascending with wrap-around.
  - The first set bit is g.
  - req_ready[g] = can_accept; all other req_ready bits are 0.
  - If no req_valid bit is set, no grant is made and req_ready=0.
- Accept: a transfer occurs when req_valid[g] && req_ready[g]. At the next edge:
  - rsp_valid=1, rsp_id=g, rsp_check=f(g).
  - last=g.
  - chk_cnt increments if f(g)=1.
- Latency: a result is visible exactly 1 cycle after acceptance.
- chk_cnt saturates at 2^CW-1 and never wraps.
- Drain: when rsp_valid && rsp_ready and there is no accept, rsp_valid goes to 0 at the next edge.
- Drain and accept in the same cycle: the buffer is reloaded with the new result and rsp_valid stays 1. Throughput is 1 result per cycle under continuous rsp_ready=1.
- Stall: while rsp_valid=1 and rsp_ready=0:
  - All req_ready bits are 0.
  - rsp_* stay stable.
  - last is unchanged.
- The pointer advances only on an accept. A requester that keeps req_valid asserted is served at least once every NREQ accepts (no starvation).
- Requester obligation: once req_valid[i] is raised, hold req_valid[i], its req_bus slice and req_sel[i] stable until req_ready[i]. The block does not check this.
- NREQ=1: the arbiter degenerates to req_ready[0]=can_accept, and rsp_id is always 0.
- rsp_ready while rsp_valid=0 has no effect.

Decomposition:
- Shared package holds:
  - constant PAR_WORD_W=32;
  - constants CHK_ODD=1'b1 and CHK_EVEN=1'b0;
  - a function that computes the check from word and sel, reused by any other client of the parity check.
- One sub-module is natural: rr_arb (parameter N; inputs req[N], last[IDW], en; outputs gnt onehot[N], gnt_idx[IDW]).
  - It is purely combinational.
  - The pointer register, response buffer and counter stay in parity_rr_sched.

Test Plan:
- Reset and single request:
  - Stimulus: rst=1 for 2 cycles; then req_valid=0001, bus0=32'h0000_0007, sel0=1, rsp_ready=1.
  - Required: req_ready=0001 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_check=1, chk_cnt=1.
- Even mode:
  - Stimulus: bus1=32'h0000_0003, sel1=0, only req_valid[1] set.
  - Required: rsp_id=1, rsp_check=1; chk_cnt increments by 1.
- Round-robin fairness:
  - Stimulus: req_valid=1111 held for 8 cycles with rsp_ready=1.
  - Required: grant order 0,1,2,3,0,1,2,3 with one result per cycle. Then after last=1 and req_valid=1001, the next grant is 3, then 0.
- Backpressure:
  - Stimulus: rsp_ready=0 while the buffer is full and req_valid=0110.
  - Required: req_ready=0000; rsp_id/rsp_check hold for 5 cycles. After rsp_ready=1 for one cycle, the new result loads on the same edge that the old one drains, with rsp_valid staying 1.
- Counter saturation:
  - Stimulus: CW=2; five accepts of bus=32'h1 with sel=1.
  - Required: chk_cnt reads 1,2,3,3,3.
- Reset mid-operation:
  - Stimulus: assert rst while rsp_valid=1 and req_valid=1111.
  - Required: next cycle rsp_valid=0, chk_cnt=0, and req_ready=0 during rst. After release the first grant goes to requester 0.
